// File: rtl/connect_scoreboard_seq_pkg.sv
// connect4_pkg: shared definitions for the sequential Connect-N scoreboard.
//   - cell codes (board contents) and winner codes (result encoding)
//   - direction enum (scan priority order) and FSM state enum
//   - idx_to_rc: raster index -> (row, col) for a grid COLS wide
package connect4_pkg;

  // Cell codes; 2'b11 is treated as empty, just like 2'b00.
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  // Winner codes reported on the result bus.
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  // Line directions, listed in checking priority order.
  typedef enum logic [1:0] {
    DIR_H  = 2'd0,  // +c
    DIR_V  = 2'd1,  // +r
    DIR_UP = 2'd2,  // +r,+c
    DIR_DN = 2'd3   // -r,+c
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] row;
    logic [7:0] col;
  } rc_t;

  // Grids are assumed to hold at most 256 cells.
  function automatic rc_t idx_to_rc(input logic [7:0] idx, input int cols);
    rc_t rc;
    int  i;
    i      = int'(idx);
    rc.row = 8'(i / cols);
    rc.col = 8'(i % cols);
    return rc;
  endfunction

  function automatic logic is_player(input logic [1:0] code);
    return (code == CELL_P1) || (code == CELL_P2);
  endfunction

endpackage

// File: rtl/connect_scoreboard_seq_if.sv
// connect_scoreboard_seq_if: request/result bus between the game-control FSM
// (master) and the scoreboard (slave).
//   master drives: eval_req, round_clear, grid_full, game_status
//   slave drives : busy, done, winner, win_row, win_col, win_dir,
//                  p1_score, p2_score, draw_score
interface connect_scoreboard_seq_if #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int SCORE_W = 8
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                     eval_req;
  logic                     round_clear;
  logic                     grid_full;
  logic [2*ROWS*COLS-1:0]   game_status;

  logic                     busy;
  logic                     done;
  logic [1:0]               winner;
  logic [RW-1:0]            win_row;
  logic [CW-1:0]            win_col;
  logic [1:0]               win_dir;
  logic [SCORE_W-1:0]       p1_score;
  logic [SCORE_W-1:0]       p2_score;
  logic [SCORE_W-1:0]       draw_score;

  modport master (
    output eval_req, round_clear, grid_full, game_status,
    input  busy, done, winner, win_row, win_col, win_dir,
           p1_score, p2_score, draw_score
  );

  modport slave (
    input  eval_req, round_clear, grid_full, game_status,
    output busy, done, winner, win_row, win_col, win_dir,
           p1_score, p2_score, draw_score
  );
endinterface

// File: rtl/connect_line_checker.sv
// connect_line_checker: combinational test of one anchor cell.
//   grid   : packed board snapshot, cell (r,c) at [2*(COLS*r+c) +: 2]
//   row/col: anchor position
//   hit    : some direction holds CONN equal player codes starting at anchor
//   player : player code of the reported line
//   dir    : lowest-numbered direction that hit
module connect_line_checker
  import connect4_pkg::*;
#(
  parameter  int ROWS = 6,
  parameter  int COLS = 7,
  parameter  int CONN = 4,
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic [2*ROWS*COLS-1:0] grid,
  input  logic [RW-1:0]          row,
  input  logic [CW-1:0]          col,
  output logic                   hit,
  output logic [1:0]             player,
  output dir_t                   dir
);

  logic [3:0] line_ok;
  logic [1:0] line_pl [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dir
      // Step per cell along the line for this direction.
      localparam int DR = (gi == 1 || gi == 2) ? 1 : ((gi == 3) ? -1 : 0);
      localparam int DC = (gi == 1) ? 0 : 1;

      logic       ok;
      logic [1:0] first;

      always_comb begin
        int r0, c0, r_end, c_end, rr, cc;
        ok    = 1'b0;
        first = CELL_EMPTY;
        rr    = 0;
        cc    = 0;
        r0    = int'(row);
        c0    = int'(col);
        r_end = r0 + DR * (CONN - 1);
        c_end = c0 + DC * (CONN - 1);
        // Only look at the line when every cell of it lies on the board.
        if (r0 < ROWS && c0 < COLS && r_end >= 0 && r_end < ROWS && c_end < COLS) begin
          first = grid[2*(COLS*r0 + c0) +: 2];
          ok    = is_player(first);
          for (int k = 1; k < CONN; k++) begin
            rr = r0 + DR * k;
            cc = c0 + DC * k;
            if (grid[2*(COLS*rr + cc) +: 2] != first) ok = 1'b0;
          end
        end
      end

      assign line_ok[gi] = ok;
      assign line_pl[gi] = first;
    end
  endgenerate

  // Walk from the highest direction down so the lowest one that hit wins.
  always_comb begin
    hit    = 1'b0;
    player = CELL_EMPTY;
    dir    = DIR_H;
    for (int d = 3; d >= 0; d--) begin
      if (line_ok[d]) begin
        hit    = 1'b1;
        player = line_pl[d];
        dir    = dir_t'(2'(d));
      end
    end
  end

endmodule

// File: rtl/connect_scoreboard_seq.sv
// connect_scoreboard_seq: sequential Connect-N scoreboard.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of connect_scoreboard_seq_if (request in, result/scores out)
// On eval_req (IDLE, no result yet) the board is snapshotted and one anchor is
// checked per clock in raster order. The checker output is registered, so the
// decision for anchor k is taken one cycle after that anchor is examined; this
// gives done at k+2 cycles after acceptance, ROWS*COLS+1 when nothing is found.
module connect_scoreboard_seq
  import connect4_pkg::*;
#(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int CONN    = 4,
  parameter int SCORE_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  connect_scoreboard_seq_if.slave  bus
);

  localparam int CELLS = ROWS * COLS;
  localparam int GW    = 2 * CELLS;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int IW    = $clog2(CELLS);
  localparam logic [IW-1:0] LAST_IDX = IW'(CELLS - 1);

  state_t             state_reg, state_next;
  logic [IW-1:0]      idx_reg, idx_next;
  logic [GW-1:0]      snap_reg, snap_next;
  logic               full_reg, full_next;

  // Registered checker result for the previously examined anchor.
  logic               chk_valid_reg, chk_valid_next;
  logic               chk_hit_reg, chk_hit_next;
  logic [1:0]         chk_pl_reg, chk_pl_next;
  dir_t               chk_dir_reg, chk_dir_next;
  logic [RW-1:0]      chk_row_reg, chk_row_next;
  logic [CW-1:0]      chk_col_reg, chk_col_next;
  logic               chk_last_reg, chk_last_next;

  logic               done_reg, done_next;
  logic [1:0]         winner_reg, winner_next;
  logic [RW-1:0]      win_row_reg, win_row_next;
  logic [CW-1:0]      win_col_reg, win_col_next;
  logic [1:0]         win_dir_reg, win_dir_next;
  logic [SCORE_W-1:0] p1_reg, p1_next;
  logic [SCORE_W-1:0] p2_reg, p2_next;
  logic [SCORE_W-1:0] draw_reg, draw_next;

  rc_t                anchor;
  logic [RW-1:0]      anchor_row;
  logic [CW-1:0]      anchor_col;
  logic               line_hit;
  logic [1:0]         line_pl;
  dir_t               line_dir;

  assign anchor     = idx_to_rc(8'(idx_reg), COLS);
  assign anchor_row = RW'(anchor.row);
  assign anchor_col = CW'(anchor.col);

  connect_line_checker #(
    .ROWS (ROWS),
    .COLS (COLS),
    .CONN (CONN)
  ) u_checker (
    .grid   (snap_reg),
    .row    (anchor_row),
    .col    (anchor_col),
    .hit    (line_hit),
    .player (line_pl),
    .dir    (line_dir)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      snap_reg      <= '0;
      full_reg      <= 1'b0;
      chk_valid_reg <= 1'b0;
      chk_hit_reg   <= 1'b0;
      chk_pl_reg    <= CELL_EMPTY;
      chk_dir_reg   <= DIR_H;
      chk_row_reg   <= '0;
      chk_col_reg   <= '0;
      chk_last_reg  <= 1'b0;
      done_reg      <= 1'b0;
      winner_reg    <= WIN_NONE;
      win_row_reg   <= '0;
      win_col_reg   <= '0;
      win_dir_reg   <= '0;
      p1_reg        <= '0;
      p2_reg        <= '0;
      draw_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      snap_reg      <= snap_next;
      full_reg      <= full_next;
      chk_valid_reg <= chk_valid_next;
      chk_hit_reg   <= chk_hit_next;
      chk_pl_reg    <= chk_pl_next;
      chk_dir_reg   <= chk_dir_next;
      chk_row_reg   <= chk_row_next;
      chk_col_reg   <= chk_col_next;
      chk_last_reg  <= chk_last_next;
      done_reg      <= done_next;
      winner_reg    <= winner_next;
      win_row_reg   <= win_row_next;
      win_col_reg   <= win_col_next;
      win_dir_reg   <= win_dir_next;
      p1_reg        <= p1_next;
      p2_reg        <= p2_next;
      draw_reg      <= draw_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    snap_next      = snap_reg;
    full_next      = full_reg;
    chk_valid_next = chk_valid_reg;
    chk_hit_next   = chk_hit_reg;
    chk_pl_next    = chk_pl_reg;
    chk_dir_next   = chk_dir_reg;
    chk_row_next   = chk_row_reg;
    chk_col_next   = chk_col_reg;
    chk_last_next  = chk_last_reg;
    done_next      = 1'b0;
    winner_next    = winner_reg;
    win_row_next   = win_row_reg;
    win_col_next   = win_col_reg;
    win_dir_next   = win_dir_reg;
    p1_next        = p1_reg;
    p2_next        = p2_reg;
    draw_next      = draw_reg;

    if (bus.round_clear) begin
      // Ends the round from any state; a pending eval_req is dropped.
      state_next   = ST_IDLE;
      winner_next  = WIN_NONE;
      win_row_next = '0;
      win_col_next = '0;
      win_dir_next = '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (bus.eval_req && winner_reg == WIN_NONE) begin
            snap_next      = bus.game_status;
            full_next      = bus.grid_full;
            idx_next       = '0;
            chk_valid_next = 1'b0;
            state_next     = ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (chk_valid_reg && chk_hit_reg) begin
            winner_next  = chk_pl_reg;
            win_row_next = chk_row_reg;
            win_col_next = chk_col_reg;
            win_dir_next = chk_dir_reg;
            done_next    = 1'b1;
            if (chk_pl_reg == CELL_P1) begin
              if (p1_reg != '1) p1_next = p1_reg + 1'b1;
            end else begin
              if (p2_reg != '1) p2_next = p2_reg + 1'b1;
            end
            state_next = ST_HOLD;
          end else if (chk_valid_reg && chk_last_reg) begin
            // Whole board scanned: a full board is a draw, otherwise no result.
            done_next = 1'b1;
            if (full_reg) begin
              winner_next = WIN_DRAW;
              if (draw_reg != '1) draw_next = draw_reg + 1'b1;
            end
            state_next = ST_HOLD;
          end else begin
            chk_valid_next = 1'b1;
            chk_hit_next   = line_hit;
            chk_pl_next    = line_pl;
            chk_dir_next   = line_dir;
            chk_row_next   = anchor_row;
            chk_col_next   = anchor_col;
            chk_last_next  = (idx_reg == LAST_IDX);
            if (idx_reg != LAST_IDX) idx_next = idx_reg + 1'b1;
          end
        end

        ST_HOLD: begin
          state_next = ST_IDLE;
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = (state_reg == ST_SCAN);
  assign bus.done       = done_reg;
  assign bus.winner     = winner_reg;
  assign bus.win_row    = win_row_reg;
  assign bus.win_col    = win_col_reg;
  assign bus.win_dir    = win_dir_reg;
  assign bus.p1_score   = p1_reg;
  assign bus.p2_score   = p2_reg;
  assign bus.draw_score = draw_reg;

endmodule

// File: tb/tb_connect_scoreboard_seq.sv
// Directed bench for connect_scoreboard_seq: a default-width instance for the
// main scenarios and a SCORE_W=2 instance for score saturation.
module tb_connect_scoreboard_seq;
  import connect4_pkg::*;

  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int CONN = 4;
  localparam int GW   = 2 * ROWS * COLS;

  logic clk;
  logic rst_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  connect_scoreboard_seq_if #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(8)) bus ();
  connect_scoreboard_seq_if #(.ROWS(ROWS), .COLS(COLS), .SCORE_W(2)) sbus ();

  connect_scoreboard_seq #(.ROWS(ROWS), .COLS(COLS), .CONN(CONN), .SCORE_W(8)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  connect_scoreboard_seq #(.ROWS(ROWS), .COLS(COLS), .CONN(CONN), .SCORE_W(2)) dut_sat (
    .clock (clk),
    .reset (rst_n),
    .bus   (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [GW-1:0] put(input logic [GW-1:0] g, input int r, input int c,
                                        input logic [1:0] v);
    g[2*(COLS*r + c) +: 2] = v;
    return g;
  endfunction

  function automatic logic [GW-1:0] grid_p1_row0();
    logic [GW-1:0] g = '0;
    for (int c = 0; c < 4; c++) g = put(g, 0, c, 2'b01);
    return g;
  endfunction

  function automatic logic [GW-1:0] grid_p2_diag();
    logic [GW-1:0] g = '0;
    g = put(g, 5, 3, 2'b10);
    g = put(g, 4, 4, 2'b10);
    g = put(g, 3, 5, 2'b10);
    g = put(g, 2, 6, 2'b10);
    return g;
  endfunction

  function automatic logic [GW-1:0] grid_draw();
    logic [GW-1:0] g = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        g = put(g, r, c, (((c / 2) + r) % 2 == 0) ? 2'b01 : 2'b10);
    return g;
  endfunction

  task automatic pulse_clear();
    bus.round_clear = 1'b1;
    @(posedge clk); #1;
    bus.round_clear = 1'b0;
  endtask

  // Issue eval_req and count cycles to done (-1 if it never comes).
  // At cycle inject_cyc a second eval_req is raised and the live board wiped.
  task automatic run_eval(input int inject_cyc, output int lat);
    bus.eval_req = 1'b1;
    @(posedge clk); #1;
    bus.eval_req = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      if (n == inject_cyc) begin
        bus.eval_req    = 1'b1;
        bus.game_status = '0;
      end
      @(posedge clk); #1;
      if (n == inject_cyc) bus.eval_req = 1'b0;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    $display("eval: latency=%0d winner=%b row=%0d col=%0d dir=%0d p1=%0d p2=%0d draw=%0d",
             lat, bus.winner, bus.win_row, bus.win_col, bus.win_dir,
             bus.p1_score, bus.p2_score, bus.draw_score);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.eval_req = 1'b0; bus.round_clear = 1'b0; bus.grid_full = 1'b0; bus.game_status = '0;
    sbus.eval_req = 1'b0; sbus.round_clear = 1'b0; sbus.grid_full = 1'b0; sbus.game_status = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset_busy_done: got %b expected 00", {bus.busy, bus.done}); else pass_cnt++;
    total_cnt++; if (bus.winner !== 2'b00) $display("FAIL reset_winner: got %b expected 00", bus.winner); else pass_cnt++;
    total_cnt++; if ({bus.win_row, bus.win_col, bus.win_dir} !== '0) $display("FAIL reset_win_pos: got %0d/%0d/%0d expected 0/0/0", bus.win_row, bus.win_col, bus.win_dir); else pass_cnt++;
    total_cnt++; if ({bus.p1_score, bus.p2_score, bus.draw_score} !== '0) $display("FAIL reset_scores: got %0d/%0d/%0d expected 0/0/0", bus.p1_score, bus.p2_score, bus.draw_score); else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL reset_idle_busy: got %b expected 0", bus.busy); else pass_cnt++;
    $display("reset: released");
  endtask

  task automatic test_p1_horizontal();
    int lat;
    bus.game_status = grid_p1_row0();
    bus.grid_full   = 1'b0;
    run_eval(0, lat);
    total_cnt++; if (lat !== 2) $display("FAIL p1h_latency: got %0d expected 2", lat); else pass_cnt++;
    total_cnt++; if (bus.winner !== 2'b01) $display("FAIL p1h_winner: got %b expected 01", bus.winner); else pass_cnt++;
    total_cnt++; if ({bus.win_row, bus.win_col, bus.win_dir} !== '0) $display("FAIL p1h_pos: got %0d/%0d/%0d expected 0/0/0", bus.win_row, bus.win_col, bus.win_dir); else pass_cnt++;
    total_cnt++; if (bus.p1_score !== 8'd1) $display("FAIL p1h_score: got %0d expected 1", bus.p1_score); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (bus.done !== 1'b0) $display("FAIL p1h_done_pulse: got %b expected 0", bus.done); else pass_cnt++;
    // Result is held, so a new request must not start a scan.
    bus.eval_req = 1'b1;
    @(posedge clk); #1;
    bus.eval_req = 1'b0;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL p1h_ignored_busy: got %b expected 0", bus.busy); else pass_cnt++;
    total_cnt++; if (bus.winner !== 2'b01) $display("FAIL p1h_result_held: got %b expected 01", bus.winner); else pass_cnt++;
    pulse_clear();
    total_cnt++; if (bus.winner !== 2'b00) $display("FAIL p1h_clear_winner: got %b expected 00", bus.winner); else pass_cnt++;
    total_cnt++; if (bus.p1_score !== 8'd1) $display("FAIL p1h_clear_score: got %0d expected 1", bus.p1_score); else pass_cnt++;
  endtask

  task automatic test_p2_diagonal();
    int lat;
    bus.game_status = grid_p2_diag();
    run_eval(0, lat);
    total_cnt++; if (lat !== 40) $display("FAIL p2d_latency: got %0d expected 40", lat); else pass_cnt++;
    total_cnt++; if (bus.winner !== 2'b10) $display("FAIL p2d_winner: got %b expected 10", bus.winner); else pass_cnt++;
    total_cnt++; if ({bus.win_row, bus.win_col} !== {3'd5, 3'd3}) $display("FAIL p2d_anchor: got %0d/%0d expected 5/3", bus.win_row, bus.win_col); else pass_cnt++;
    total_cnt++; if (bus.win_dir !== 2'd3) $display("FAIL p2d_dir: got %0d expected 3", bus.win_dir); else pass_cnt++;
    total_cnt++; if (bus.p2_score !== 8'd1) $display("FAIL p2d_score: got %0d expected 1", bus.p2_score); else pass_cnt++;
    pulse_clear();
  endtask

  task automatic test_draw();
    int lat;
    bus.game_status = grid_draw();
    bus.grid_full   = 1'b1;
    run_eval(0, lat);
    total_cnt++; if (lat !== 43) $display("FAIL draw_latency: got %0d expected 43", lat); else pass_cnt++;
    total_cnt++; if (bus.winner !== 2'b11) $display("FAIL draw_winner: got %b expected 11", bus.winner); else pass_cnt++;
    total_cnt++; if (bus.draw_score !== 8'd1) $display("FAIL draw_score: got %0d expected 1", bus.draw_score); else pass_cnt++;
    pulse_clear();
    bus.grid_full = 1'b0;
    run_eval(0, lat);
    total_cnt++; if (lat !== 43) $display("FAIL nores_latency: got %0d expected 43", lat); else pass_cnt++;
    total_cnt++; if (bus.winner !== 2'b00) $display("FAIL nores_winner: got %b expected 00", bus.winner); else pass_cnt++;
    total_cnt++; if (bus.draw_score !== 8'd1) $display("FAIL nores_draw_score: got %0d expected 1", bus.draw_score); else pass_cnt++;
    pulse_clear();
  endtask

  task automatic test_eval_during_scan();
    int lat;
    bus.game_status = grid_p2_diag();
    run_eval(5, lat);
    total_cnt++; if (lat !== 40) $display("FAIL midreq_latency: got %0d expected 40", lat); else pass_cnt++;
    total_cnt++; if (bus.winner !== 2'b10) $display("FAIL midreq_winner: got %b expected 10", bus.winner); else pass_cnt++;
    total_cnt++; if (bus.p2_score !== 8'd2) $display("FAIL midreq_score: got %0d expected 2", bus.p2_score); else pass_cnt++;
    pulse_clear();
  endtask

  task automatic test_abort();
    bit seen;
    bus.game_status = grid_draw();
    bus.grid_full   = 1'b1;
    bus.eval_req = 1'b1;
    @(posedge clk); #1;
    bus.eval_req = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL abort_busy_before: got %b expected 1", bus.busy); else pass_cnt++;
    pulse_clear();
    seen = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL abort_no_done: got %b expected 0", seen); else pass_cnt++;
    total_cnt++; if ({bus.busy, bus.winner} !== 3'b000) $display("FAIL abort_idle: got busy=%b winner=%b expected 0/00", bus.busy, bus.winner); else pass_cnt++;
    total_cnt++; if (bus.draw_score !== 8'd1) $display("FAIL abort_draw_score: got %0d expected 1", bus.draw_score); else pass_cnt++;
    // Clear and request together: the clear wins.
    bus.eval_req = 1'b1;
    bus.round_clear = 1'b1;
    @(posedge clk); #1;
    bus.eval_req = 1'b0;
    bus.round_clear = 1'b0;
    total_cnt++; if (bus.busy !== 1'b0) $display("FAIL clear_vs_req_busy: got %b expected 0", bus.busy); else pass_cnt++;
    $display("abort: done_seen=%b winner=%b", seen, bus.winner);
  endtask

  task automatic test_saturation();
    int lat;
    int exp_score;
    sbus.game_status = grid_p1_row0();
    sbus.grid_full   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sbus.eval_req = 1'b1;
      @(posedge clk); #1;
      sbus.eval_req = 1'b0;
      lat = -1;
      for (int n = 1; n <= 10; n++) begin
        @(posedge clk); #1;
        if (sbus.done) begin
          lat = n;
          break;
        end
      end
      exp_score = (i + 1 > 3) ? 3 : i + 1;
      $display("sat round %0d: latency=%0d p1=%0d", i, lat, sbus.p1_score);
      total_cnt++; if (lat !== 2) $display("FAIL sat_latency_%0d: got %0d expected 2", i, lat); else pass_cnt++;
      total_cnt++; if (int'(sbus.p1_score) !== exp_score) $display("FAIL sat_score_%0d: got %0d expected %0d", i, sbus.p1_score, exp_score); else pass_cnt++;
      sbus.round_clear = 1'b1;
      @(posedge clk); #1;
      sbus.round_clear = 1'b0;
    end
  endtask

  task automatic test_reset_mid_scan();
    bus.game_status = grid_draw();
    bus.grid_full   = 1'b1;
    bus.eval_req = 1'b1;
    @(posedge clk); #1;
    bus.eval_req = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total_cnt++; if (bus.busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected 1", bus.busy); else pass_cnt++;
    #3;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({bus.busy, bus.done, bus.winner} !== 4'b0000) $display("FAIL rstmid_status: got busy=%b done=%b winner=%b expected 0/0/00", bus.busy, bus.done, bus.winner); else pass_cnt++;
    total_cnt++; if ({bus.p1_score, bus.p2_score, bus.draw_score} !== '0) $display("FAIL rstmid_scores: got %0d/%0d/%0d expected 0/0/0", bus.p1_score, bus.p2_score, bus.draw_score); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    $display("reset mid-scan: busy=%b", bus.busy);
  endtask

  initial begin
    test_reset();
    test_p1_horizontal();
    test_p2_diagonal();
    test_draw();
    test_eval_during_scan();
    test_abort();
    test_saturation();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/connect_scoreboard_seq.md
# connect_scoreboard_seq

Parametrised, sequential successor to the combinational Connect-N scoreboard. On request, it snapshots the packed game grid and scans one anchor cell per clock for a CONN-in-a-row line in four directions. It reports the winner, the winning line's position and direction, or a draw, and keeps saturating per-round tallies. It sits between the game-control FSM (which issues eval_req after each move) and the display/score logic.

## Interface
- ROWS, 6, grid rows; row 0 is the bottom row.
- COLS, 7, grid columns.
- CONN, 4, line length needed to win; 2 ≤ CONN ≤ min(ROWS, COLS).
- SCORE_W, 8, width of each score counter.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- eval_req  in  1  one-cycle request to evaluate game_status; accepted only in IDLE.
- round_clear  in  1  ends the round; clears the result and aborts any scan.
- grid_full  in  1  board-full flag, sampled together with game_status.
- game_status  in  2*ROWS*COLS  cell (r,c) occupies bits [2*(COLS*r+c)+:2]; codes: 01 = P1, 10 = P2, 00/11 = empty.
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when a result is decided.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw.
- win_row  out  max(1,$clog2(ROWS))  anchor row of the winning line.
- win_col  out  max(1,$clog2(COLS))  anchor column of the winning line.
- win_dir  out  2  0 horizontal (+c), 1 vertical (+r), 2 up-diagonal (+r,+c), 3 down-diagonal (−r,+c).
- p1_score, p2_score, draw_score  out  SCORE_W  rounds won by P1, rounds won by P2, rounds drawn.

## Operation
- FSM states: IDLE, SCAN, HOLD.
- IDLE:
  - eval_req=1 and winner=00: latch game_status and grid_full, set idx=0, go to SCAN.
  - eval_req while winner≠00: ignored; the round is already decided.
- SCAN: each cycle, evaluate the anchor at idx = COLS*r + c in raster order, with directions checked in priority 0..3.
  - A direction is checked only if the whole line fits inside the grid.
  - A line requires all CONN cells to hold the same player code (01 or 10).
  - First hit: register winner, win_row, win_col and win_dir, pulse done, increment that player's score, go to HOLD.
  - idx = ROWS*COLS−1 with no hit: if the latched grid_full=1, set winner=11, increment draw_score and pulse done. Otherwise winner stays 00 and done still pulses (evaluation complete, no result). In both cases go to HOLD.
- HOLD: return to IDLE on the next cycle. Result outputs hold their values until round_clear or reset.
- round_clear, in any state: next state is IDLE; winner and win_* are cleared to 0; scores are unchanged; a scan in progress is aborted with no done pulse.
- round_clear and eval_req in the same cycle: round_clear wins and eval_req is dropped.
- Both players holding lines (illegal board): the first hit in scan order is reported.
- Scores saturate at 2^SCORE_W−1 and never wrap.
- game_status changing during SCAN has no effect, because the snapshot is used.

## Timing
- Reset values: busy=0, done=0, winner=00, win_row=0, win_col=0, win_dir=0, all scores 0, state IDLE.
- busy is high in the cycle after eval_req is accepted and stays high through SCAN. It is low in HOLD and IDLE.
- Win latency: for a winning anchor at idx k, done and the registered results appear k+2 cycles after the eval_req sampling edge.
- No-win latency: ROWS*COLS+1 cycles.
- Scores update on the same edge that raises done.
- Asserting reset mid-scan returns the block to its reset state immediately (asynchronous).

## Structure
- Package connect4_pkg holds:
  - cell codes and winner codes;
  - the direction enum and the FSM state enum;
  - the function idx_to_rc.
- Sub-module connect_line_checker is combinational. Its inputs are the snapshot and the anchor (r,c). Its outputs are hit, player and dir, using the 0..3 priority. It is generated from ROWS, COLS and CONN.
- The top level holds the FSM, the idx counter, the snapshot register, result registers and the saturating counters.

## Test plan
- Reset: hold reset=0 for 3 cycles. All outputs are 0. Release; busy stays 0 with no eval_req.
- P1 horizontal win at (0,0)–(0,3): done pulses 2 cycles after eval_req. Expect winner=01, win_row=0, win_col=0, win_dir=0, p1_score=1.
- P2 down-diagonal win at (5,3),(4,4),(3,5),(2,6): anchor idx 38, so done pulses after 40 cycles. Expect winner=10, win_dir=3, p2_score=1.
- Draw: fill the grid with cell = P1 if (c/2 + r) even, else P2, with grid_full=1. Expect done after 43 cycles, winner=11, draw_score=1. Repeat with grid_full=0: expect winner=00 and draw_score unchanged.
- Saturation: with SCORE_W=2, run 5 P1-win rounds separated by round_clear. p1_score must stay at 3.
- Abort/ignore:
  - eval_req during SCAN is ignored (latency unchanged).
  - round_clear mid-scan gives no done pulse and winner=00.
  - reset low mid-scan zeroes all outputs asynchronously.
